wishbone_wait_sram: RTL

- Parametrised Wishbone slave: word-addressed on-chip SRAM with byte-lane writes, programmable wait states, a base-address window and an optional read-only mode.
- Out-of-window or forbidden accesses are answered with wb_err, never with silence.
- Generalises the testbench always-ack stub into a reusable slave for SoC integration and as a bus-fabric test target.
- Attaches to one slave port of the interconnect using the standard WISHBONE_SLAVE(wb) port group.

---
 rtl/wishbone_wait_sram.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wishbone_wait_sram.sv
// Wishbone classic slave: word-addressed SRAM with byte-lane writes, programmable
// wait states, a base-address window and an optional read-only mode.
// Out-of-window or forbidden accesses terminate with wb_err instead of hanging the bus.
module wishbone_wait_sram #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           TAG_WIDTH   = 3,
    parameter int unsigned           DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 0,
    parameter bit                    READ_ONLY   = 1'b0,
    localparam int unsigned          SEL_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [TAG_WIDTH-1:0]  wb_tag,
    input  logic [SEL_WIDTH-1:0]  wb_sel,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [DATA_WIDTH-1:0] wb_mosi,
    output logic [DATA_WIDTH-1:0] wb_miso,
    output logic                  wb_ack,
    output logic                  wb_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  respond;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic                  access_ok;
    logic                  mem_we;
    logic [IDX_W-1:0]      idx;
    logic                  ack_d, err_d;
    logic [DATA_WIDTH-1:0] miso_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The tag is accepted for bus compatibility but carries no meaning here.
    logic unused_tag;
    assign unused_tag = ^wb_tag;

    // Both compares are full-width unsigned, so addresses above the window never alias
    // back into it through the truncated index.
    assign offset    = wb_adr - BASE_ADDR;
    assign in_range  = (wb_adr >= BASE_ADDR) && (offset < ADDR_WIDTH'(DEPTH));
    assign idx       = offset[IDX_W-1:0];
    assign access_ok = in_range && !(wb_we && READ_ONLY);
    assign mem_we    = respond && access_ok && wb_we;

    // Next-state logic: count wait states, abort on dropped cyc, single-cycle response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        respond = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc && wb_stb) begin
                    if (WAIT_STATES == 0) begin
                        respond = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = 8'(WAIT_STATES - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!wb_cyc) begin
                    state_d = StIdle;
                end else if (cnt_q == 8'd0) begin
                    respond = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                // stb is still high while the master reacts to ack, so it is ignored here.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Response decode from the request held on the bus at the response edge.
    always_comb begin
        ack_d  = respond && access_ok;
        err_d  = respond && !access_ok;
        miso_d = '0;
        if (respond && access_ok && !wb_we) begin
            miso_d = mem[idx];
        end
    end

    // State, counter and registered bus outputs with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            wb_ack  <= 1'b0;
            wb_err  <= 1'b0;
            wb_miso <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_ack  <= ack_d;
            wb_err  <= err_d;
            wb_miso <= miso_d;
        end
    end

    // Byte-lane write, committed only on the ack edge; reset on that edge drops it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && mem_we) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (wb_sel[i]) begin
                    mem[idx][8*i +: 8] <= wb_mosi[8*i +: 8];
                end
            end
        end
    end

endmodule
